// File: rtl/core_types_pkg.sv
// core_types_pkg: shared core types, including the LSU request bundle, FSM states and lane widths.
package core_types_pkg;
    localparam int N_BITS        = 32;
    localparam int DMEM_BE_WIDTH = N_BITS / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} lsu_state_e;
    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} mem_len_e;

    typedef struct packed {
        logic       vld;
        logic       mtype;
        logic [1:0] len;
    } dmem_req_ctrl_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
    } rf_ctrl_t;

    // len=3 is reserved and only counts as faulting when trapping is enabled
    function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] off);
        return (len == HALF && off[0]) || (len == WORD && off != 2'b00) || len == 2'd3;
    endfunction
endpackage

// File: rtl/core_lsu_align.sv
// core_lsu_align: combinational byte-lane steering for stores and extract/extend for loads.
module core_lsu_align
    import core_types_pkg::*;
(
    input  logic [1:0]               len,
    input  logic [1:0]               off,
    input  logic                     zext,
    input  logic [N_BITS-1:0]        wdata,
    input  logic [N_BITS-1:0]        rdata,
    output logic [DMEM_BE_WIDTH-1:0] be,
    output logic [N_BITS-1:0]        lane_wdata,
    output logic [N_BITS-1:0]        ext_rdata
);
    logic [1:0]        aoff;
    logic [N_BITS-1:0] shifted;

    // misaligned offsets are forced down to the access size; reserved len acts as a word
    always_comb begin
        aoff       = len == BYTE ? off : len == HALF ? {off[1], 1'b0} : 2'b00;
        be         = len == BYTE ? DMEM_BE_WIDTH'(1) << aoff :
                     len == HALF ? DMEM_BE_WIDTH'(3) << aoff : '1;
        lane_wdata = len == BYTE ? {(N_BITS/8){wdata[7:0]}} :
                     len == HALF ? {(N_BITS/16){wdata[15:0]}} : wdata;
        shifted    = rdata >> {aoff, 3'b000};
        ext_rdata  = len == BYTE ? {{(N_BITS-8){~zext & shifted[7]}}, shifted[7:0]} :
                     len == HALF ? {{(N_BITS-16){~zext & shifted[15]}}, shifted[15:0]} : shifted;
    end
endmodule

// File: rtl/core_lsu.sv
// core_lsu: single-outstanding load/store unit between execute, the data-memory bus and writeback.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses (misalign_exc) instead of forcing alignment.
module core_lsu
    import core_types_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_vld,
    output logic                     req_rdy,
    input  dmem_req_ctrl_t           req_ctrl,
    input  logic                     req_unsigned,
    input  logic [N_BITS-1:0]        req_addr,
    input  logic [N_BITS-1:0]        req_wdata,
    input  rf_ctrl_t                 req_rf,
    output logic                     mem_req_vld,
    input  logic                     mem_req_rdy,
    output logic [N_BITS-1:0]        mem_addr,
    output logic                     mem_we,
    output logic [DMEM_BE_WIDTH-1:0] mem_be,
    output logic [N_BITS-1:0]        mem_wdata,
    input  logic                     mem_rsp_vld,
    input  logic [N_BITS-1:0]        mem_rdata,
    output logic                     wb_vld,
    output logic [4:0]               wb_rd,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic [N_BITS-1:0]        wb_data,
    output logic                     misalign_exc
`else
    output logic [N_BITS-1:0]        wb_data
`endif
);
    lsu_state_e               state, state_nxt;
    logic                     accept, fault;
    logic [1:0]               len_q, off_q;
    logic                     zext_q;
    rf_ctrl_t                 rf_q;
    logic [DMEM_BE_WIDTH-1:0] req_be, unused_be;
    logic [N_BITS-1:0]        req_lane, rsp_data, unused_rdata, unused_wdata;

    assign accept = state == IDLE && req_vld && req_ctrl.vld;
`ifdef LSU_MISALIGN_TRAP_EN
    assign fault = is_misaligned(req_ctrl.len, req_addr[1:0]);
`else
    assign fault = 1'b0;
`endif

    core_lsu_align u_req_align (
        .len        (req_ctrl.len),
        .off        (req_addr[1:0]),
        .zext       (req_unsigned),
        .wdata      (req_wdata),
        .rdata      ('0),
        .be         (req_be),
        .lane_wdata (req_lane),
        .ext_rdata  (unused_rdata)
    );

    core_lsu_align u_rsp_align (
        .len        (len_q),
        .off        (off_q),
        .zext       (zext_q),
        .wdata      ('0),
        .rdata      (mem_rdata),
        .be         (unused_be),
        .lane_wdata (unused_wdata),
        .ext_rdata  (rsp_data)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // responses outside WAIT_RSP (stale or same-cycle as handshake) are ignored
    always_comb begin
        state_nxt = state == IDLE ? (accept && !fault ? REQ : IDLE) :
                    state == REQ  ? (mem_req_rdy ? (mem_we ? IDLE : WAIT_RSP) : REQ) :
                    (mem_rsp_vld ? IDLE : WAIT_RSP);
    end

    always_comb begin
        req_rdy     = state == IDLE;
        mem_req_vld = state == REQ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            len_q     <= 2'b00;
            off_q     <= 2'b00;
            zext_q    <= 1'b0;
            rf_q      <= '0;
            wb_vld    <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
        end else begin
            wb_vld <= 1'b0;
            if (accept && !fault) begin
                mem_addr  <= {req_addr[N_BITS-1:2], 2'b00};
                mem_we    <= req_ctrl.mtype;
                mem_be    <= req_be;
                mem_wdata <= req_lane;
                len_q     <= req_ctrl.len;
                off_q     <= req_addr[1:0];
                zext_q    <= req_unsigned;
                rf_q      <= req_rf;
            end
            if (state == WAIT_RSP && mem_rsp_vld) begin
                wb_vld  <= rf_q.vld && rf_q.rd != 5'd0;
                wb_rd   <= rf_q.rd;
                wb_data <= rsp_data;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) misalign_exc <= 1'b0;
        else        misalign_exc <= accept && fault;
`endif
endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: randomized and directed checks of core_lsu against a behavioural lane/extend model.
module tb_core_lsu;
    import core_types_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_vld = 1'b0;
    logic           req_rdy;
    dmem_req_ctrl_t req_ctrl = '0;
    logic           req_unsigned = 1'b0;
    logic [31:0]    req_addr = '0;
    logic [31:0]    req_wdata = '0;
    rf_ctrl_t       req_rf = '0;
    logic           mem_req_vld;
    logic           mem_req_rdy = 1'b0;
    logic [31:0]    mem_addr;
    logic           mem_we;
    logic [3:0]     mem_be;
    logic [31:0]    mem_wdata;
    logic           mem_rsp_vld = 1'b0;
    logic [31:0]    mem_rdata = '0;
    logic           wb_vld;
    logic [4:0]     wb_rd;
    logic [31:0]    wb_data;
    logic           misalign_exc;
    int             vectors = 0;
    int             miscompares = 0;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
    assign misalign_exc = 1'b0;
`endif

    always #5 clk = ~clk;

    core_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .req_ctrl     (req_ctrl),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rf       (req_rf),
        .mem_req_vld  (mem_req_vld),
        .mem_req_rdy  (mem_req_rdy),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rsp_vld  (mem_rsp_vld),
        .mem_rdata    (mem_rdata),
        .wb_vld       (wb_vld),
        .wb_rd        (wb_rd),
`ifdef LSU_MISALIGN_TRAP_EN
        .wb_data      (wb_data),
        .misalign_exc (misalign_exc)
`else
        .wb_data      (wb_data)
`endif
    );

    function automatic int m_off(input int len, input int a);
        return len == 0 ? a % 4 : len == 1 ? (a % 4) / 2 * 2 : 0;
    endfunction

    function automatic logic [3:0] m_be(input int len, input int a);
        return len == 0 ? 4'(1 << m_off(len, a)) : len == 1 ? 4'(3 << m_off(len, a)) : 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int len, input logic [31:0] w);
        return len == 0 ? 32'(w[7:0]) * 32'h0101_0101 : len == 1 ? 32'(w[15:0]) * 32'h0001_0001 : w;
    endfunction

    function automatic logic [31:0] m_load(input int len, input int a, input logic [31:0] r, input bit u);
        logic [31:0] mask, v;
        mask = len == 0 ? 32'hFF : len == 1 ? 32'hFFFF : 32'hFFFF_FFFF;
        v = (r >> (8 * m_off(len, a))) & mask;
        if (!u && len < 2 && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
        return v;
    endfunction

    function automatic bit m_fault(input int len, input int a);
        return TRAP && ((len == 1 && a % 2 == 1) || (len == 2 && a % 4 != 0) || len == 3);
    endfunction

    // One transaction: accept, optional bus stall, optional response delay, writeback.
    task automatic run_txn(input string name, input bit st, input int len, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd_data, input bit u,
                           input bit rfv, input logic [4:0] rd, input int stall, input int dly,
                           input bit early);
        logic [31:0] ea, ew;
        logic [3:0]  eb;
        ea = {addr[31:2], 2'b00};
        eb = m_be(len, int'(addr[1:0]));
        ew = m_wdata(len, wd);
        req_vld = 1'b1;
        req_ctrl = '{vld: 1'b1, mtype: st, len: 2'(len)};
        req_addr = addr;
        req_wdata = wd;
        req_unsigned = u;
        req_rf = '{vld: rfv, rd: rd};
        @(negedge clk);
        req_vld = 1'b0;
        req_ctrl = '0;
        req_addr = $urandom;
        req_wdata = $urandom;
        if (m_fault(len, int'(addr[1:0]))) begin
            vectors++;
            if (misalign_exc !== 1'b1 || mem_req_vld !== 1'b0 || req_rdy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s trap: exc=%b mem_req_vld=%b req_rdy=%b required 1 0 1", name, misalign_exc, mem_req_vld, req_rdy);
            end
            @(negedge clk);
            vectors++;
            if (misalign_exc !== 1'b0 || mem_req_vld !== 1'b0 || wb_vld !== 1'b0) begin
                miscompares++;
                $display("FAIL %s trap_after: exc=%b mem_req_vld=%b wb_vld=%b required 0 0 0", name, misalign_exc, mem_req_vld, wb_vld);
            end
            return;
        end
        vectors++;
        if (mem_req_vld !== 1'b1 || req_rdy !== 1'b0 || mem_addr !== ea || mem_be !== eb ||
            mem_we !== st || (st && mem_wdata !== ew)) begin
            miscompares++;
            $display("FAIL %s req: vld=%b rdy=%b addr=%h be=%b we=%b wd=%h required 1 0 %h %b %b %h",
                     name, mem_req_vld, req_rdy, mem_addr, mem_be, mem_we, mem_wdata, ea, eb, st, ew);
        end
        mem_req_rdy = stall == 0;
        if (early && stall == 0) begin mem_rsp_vld = 1'b1; mem_rdata = $urandom; end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            vectors++;
            if (mem_req_vld !== 1'b1 || req_rdy !== 1'b0 || mem_addr !== ea || mem_be !== eb || mem_we !== st) begin
                miscompares++;
                $display("FAIL %s stall%0d: vld=%b rdy=%b addr=%h be=%b required 1 0 %h %b", name, i, mem_req_vld, req_rdy, mem_addr, mem_be, ea, eb);
            end
            if (i == stall - 1) begin
                mem_req_rdy = 1'b1;
                if (early) begin mem_rsp_vld = 1'b1; mem_rdata = $urandom; end
            end
        end
        @(negedge clk);
        mem_req_rdy = 1'b0;
        mem_rsp_vld = 1'b0;
        vectors++;
        if (mem_req_vld !== 1'b0 || req_rdy !== st || wb_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL %s post_hs: vld=%b rdy=%b wb_vld=%b required 0 %b 0", name, mem_req_vld, req_rdy, wb_vld, st);
        end
        if (st) return;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            vectors++;
            if (req_rdy !== 1'b0 || wb_vld !== 1'b0) begin
                miscompares++;
                $display("FAIL %s wait%0d: rdy=%b wb_vld=%b required 0 0", name, i, req_rdy, wb_vld);
            end
        end
        mem_rsp_vld = 1'b1;
        mem_rdata = rd_data;
        @(negedge clk);
        mem_rsp_vld = 1'b0;
        mem_rdata = $urandom;
        vectors++;
        if (wb_vld !== (rfv && rd != 0) || req_rdy !== 1'b1 ||
            (rfv && rd != 0 && (wb_rd !== rd || wb_data !== m_load(len, int'(addr[1:0]), rd_data, u)))) begin
            miscompares++;
            $display("FAIL %s wb: vld=%b rdy=%b rd=%0d data=%h required %b 1 %0d %h", name, wb_vld, req_rdy, wb_rd, wb_data,
                     rfv && rd != 0, rd, m_load(len, int'(addr[1:0]), rd_data, u));
        end
        @(negedge clk);
        vectors++;
        if (wb_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL %s wb_pulse: wb_vld=%b required 0", name, wb_vld);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (req_rdy !== 1'b1 || mem_req_vld !== 1'b0 || mem_we !== 1'b0 || wb_vld !== 1'b0 ||
            misalign_exc !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 ||
            wb_rd !== 5'd0 || wb_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: rdy=%b mvld=%b we=%b wbv=%b exc=%b addr=%h be=%b wd=%h rd=%0d wbd=%h required 1 and zeros",
                     req_rdy, mem_req_vld, mem_we, wb_vld, misalign_exc, mem_addr, mem_be, mem_wdata, wb_rd, wb_data);
        end
    endtask

    task automatic test_directed();
        run_txn("lb_signed", 1'b0, 0, 32'h103, 32'h0, 32'h80FF_1234, 1'b0, 1'b1, 5'd3, 0, 0, 1'b0);
        run_txn("lbu", 1'b0, 0, 32'h103, 32'h0, 32'h80FF_1234, 1'b1, 1'b1, 5'd4, 0, 1, 1'b0);
        run_txn("sh", 1'b1, 1, 32'h102, 32'h0000_ABCD, 32'h0, 1'b0, 1'b1, 5'd5, 0, 0, 1'b0);
        run_txn("lw_stall", 1'b0, 2, 32'h200, 32'h0, 32'h1234_5678, 1'b0, 1'b1, 5'd6, 3, 2, 1'b0);
        run_txn("lw_rd0", 1'b0, 2, 32'h300, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd0, 1, 0, 1'b1);
        run_txn("lw_misalign", 1'b0, 2, 32'h101, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, 5'd7, 0, 0, 1'b0);
        run_txn("lh_misalign", 1'b0, 1, 32'h103, 32'h0, 32'h8001_7FFF, 1'b0, 1'b1, 5'd8, 0, 0, 1'b0);
        run_txn("len3", 1'b1, 3, 32'h40, 32'h1122_3344, 32'h0, 1'b0, 1'b0, 5'd0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_rsp();
        req_vld = 1'b1;
        req_ctrl = '{vld: 1'b1, mtype: 1'b0, len: 2'd2};
        req_addr = 32'h480;
        req_rf = '{vld: 1'b1, rd: 5'd9};
        @(negedge clk);
        req_vld = 1'b0;
        req_ctrl = '0;
        mem_req_rdy = 1'b1;
        @(negedge clk);
        mem_req_rdy = 1'b0;
        rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_vld = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_rsp_vld = 1'b0;
        vectors++;
        if (wb_vld !== 1'b0 || req_rdy !== 1'b1 || mem_req_vld !== 1'b0 || wb_data !== 32'h0) begin
            miscompares++;
            $display("FAIL stale_rsp: wb_vld=%b rdy=%b mvld=%b wb_data=%h required 0 1 0 0", wb_vld, req_rdy, mem_req_vld, wb_data);
        end
        run_txn("after_reset", 1'b0, 1, 32'h482, 32'h0, 32'h9ABC_0000, 1'b0, 1'b1, 5'd10, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++)
            run_txn("random", 1'($urandom_range(1)), int'($urandom_range(3)), $urandom, $urandom, $urandom,
                    1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(31)),
                    int'($urandom_range(3)), int'($urandom_range(2)), 1'($urandom_range(1)));
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_reset_mid_rsp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/core_lsu.md
# core_lsu

Load/store unit for the core's memory stage. It accepts one memory request per transaction from execute, described by a `dmem_req_ctrl_t` bundle, an address, store data and the destination `rf_ctrl_t`. It drives a word-wide valid/ready data-memory bus with byte-lane steering, then returns sign- or zero-extended load data to register-file writeback. Only one request is outstanding at a time; upstream sees backpressure through `req_rdy`.

## Interface
- `N_BITS`, default 32: datapath width, taken from `core_types_pkg`.
- `clk` in 1: core clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_vld` in 1: execute presents a request.
- `req_rdy` out 1: LSU can accept a request.
- `req_ctrl` in `dmem_req_ctrl_t`: `mtype` 0=load, 1=store; `len` 0=byte, 1=half, 2=word, 3=reserved. The embedded `vld` must match `req_vld`.
- `req_unsigned` in 1: zero-extend the load (LBU/LHU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `req_rf` in `rf_ctrl_t`: load destination.
- `mem_req_vld` out 1; `mem_req_rdy` in 1: memory request handshake.
- `mem_addr` out 32: word-aligned address (`[1:0]`=0).
- `mem_we` out 1: write enable.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-steered store data.
- `mem_rsp_vld` in 1; `mem_rdata` in 32: load response. Memory always accepts responses.
- `wb_vld` out 1; `wb_rd` out 5; `wb_data` out 32: writeback port.
- `misalign_exc` out 1: one-cycle pulse. Only present under `LSU_MISALIGN_TRAP_EN`.

## Operation
- FSM states:
  - IDLE: `req_rdy`=1. On `req_vld`, register ctrl, addr, lanes, data and rf, then go to REQ.
  - REQ: `mem_req_vld`=1 and all `mem_*` outputs held stable. On `mem_req_rdy`: a store returns to IDLE; a load goes to WAIT_RSP.
  - WAIT_RSP: on `mem_rsp_vld`, register the extracted data into `wb_*`, then go to IDLE.
- Lane steering uses `off = addr[1:0]`:
  - Byte: `be = 1<<off`; `wdata` byte replicated to all four lanes.
  - Half: `be = 2'b11<<off`; halfword replicated to both halves.
  - Word: `be = 4'hF`.
- Load extraction: `rdata >> (8*off)`, masked to the access length, then extended. Bit 7 (byte) or bit 15 (half) is replicated unless `req_unsigned`.
- Writeback: `wb_vld` is asserted only for loads with `req_rf.vld`=1 and `rd`≠0. Stores never write back.
- Reserved `len`=3 is treated as a word access (see Configuration).
- Reset, including mid-REQ or mid-WAIT_RSP: return to IDLE and abandon the transaction. A later stale `mem_rsp_vld` arriving in IDLE or REQ is ignored.

## Timing
- Reset values: `req_rdy`=1. `mem_req_vld`, `mem_we`, `wb_vld`, `misalign_exc` = 0. `mem_addr`, `mem_be`, `mem_wdata`, `wb_rd`, `wb_data` = 0.
- Accept in cycle 0 → `mem_req_vld` high in cycle 1. Outputs are registered; there is no combinational path from `req_*` to `mem_*`.
- Load response in cycle N → `wb_vld` pulses for exactly one cycle in N+1.
- Best-case load: accept at t0, mem handshake at t1, response at t2, writeback at t3. `req_rdy` is high again at t3.
- Best-case store: accept at t0, handshake at t1, `req_rdy` high at t2.
- `mem_req_rdy` low: all `mem_*` outputs are held unchanged.
- `mem_rsp_vld` in the same cycle as the request handshake is not legal for the bus and is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Half with `off[0]`=1, word with `off`≠0, or `len`=3 is faulting.
  - On a faulting request the LSU accepts it, pulses `misalign_exc` in the next cycle and stays in IDLE.
  - No `mem_req_vld` and no writeback are produced.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - The `misalign_exc` port is absent.
  - Offending low address bits are forced to alignment: half uses `off & 2'b10`, word uses `off = 0`.
  - The access proceeds normally.

## Structure
- Add to `core_types_pkg`:
  - `lsu_state_e` (IDLE, REQ, WAIT_RSP).
  - `mem_len_e` (BYTE=0, HALF=1, WORD=2).
  - `DMEM_BE_WIDTH = N_BITS/8`.
- Sub-module `core_lsu_align`: purely combinational; computes `be`/`wdata` steering and load extract/extend. Instantiated twice, once in the request path and once in the response path.
- FSM and registers live in `core_lsu`.

## Test plan
- LB: addr `0x103`, rdata `0x80FF_1234` → `mem_addr` `0x100`, `be` `4'b1000`, `wb_data` `0xFFFF_FF80`. The same access with `req_unsigned` → `0x0000_0080`.
- SH: addr `0x102`, wdata `0x0000_ABCD` → `mem_addr` `0x100`, `be` `4'b1100`, `mem_wdata` `0xABCD_ABCD`, `we`=1, no `wb_vld`, `req_rdy` high 2 cycles after accept.
- LW at `0x200` with `mem_req_rdy` low for 3 cycles → `mem_*` stable throughout. `wb_vld` appears 1 cycle after `rsp_vld`; `req_rdy` stays 0 until then.
- LW to rd=0, rdata `0xDEAD_BEEF` → bus transaction completes, `wb_vld` never asserts.
- With `LSU_MISALIGN_TRAP_EN`: LW at `0x101` → `misalign_exc` pulses once, `mem_req_vld` stays 0. Without the macro: same request → `mem_addr` `0x100`, `be` `4'hF`.
- Assert `rst_n` low during WAIT_RSP, then release and drive a stale `mem_rsp_vld` → all outputs at reset values, no `wb_vld`, next request served normally.
